// File: rtl/tft_ili9341_window_arbiter_if.sv
// Requester/SPI-side bundle of the ILI9341 window arbiter.
// Per-requester fields are packed {r1,r0}.
interface tft_ili9341_window_arbiter_if;
    logic [1:0]  req_valid;
    logic [17:0] req_x0;
    logic [17:0] req_x1;
    logic [17:0] req_y0;
    logic [17:0] req_y1;
    logic [1:0]  req_grant;
    logic [1:0]  req_err;
    logic [31:0] pix_data;
    logic [1:0]  pix_valid;
    logic [1:0]  pix_ready;
    logic [1:0]  done;
    logic        busy;
    logic [8:0]  spi_data;
    logic        spi_valid;
    logic        spi_ready;

    modport slave (
        input  req_valid, req_x0, req_x1, req_y0, req_y1, pix_data, pix_valid, spi_ready,
        output req_grant, req_err, pix_ready, done, busy, spi_data, spi_valid
    );

    modport master (
        output req_valid, req_x0, req_x1, req_y0, req_y1, pix_data, pix_valid, spi_ready,
        input  req_grant, req_err, pix_ready, done, busy, spi_data, spi_valid
    );
endinterface

// File: rtl/tft_ili9341_window_arbiter.sv
// Round-robin sharing of the ILI9341 {dc,byte} link between two rectangle requesters.
// Optional TFT_WIN_CLIP_EN clamps/rejects windows against the panel bounds.
module tft_ili9341_window_arbiter #(
    parameter int TFT_WIDTH  = 320,
    parameter int TFT_HEIGHT = 240
) (
    input  logic clk,
    input  logic reset,
    tft_ili9341_window_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TFT_WIDTH * TFT_HEIGHT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_CASET, S_PASET, S_RAMWR, S_PIX_HI, S_PIX_LO, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             gnt_q, gnt_d;
    logic             rr_q, rr_d;   // requester served last
    logic [8:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             win;
    logic [8:0]       ax0, ax1, ay0, ay1;
    logic             rect_ok;
    logic [9:0]       w, h;
    logic [CNT_W-1:0] npix;
    logic [15:0]      pix;

    logic [1:0]       grant_o, err_o, pix_ready_o, done_o;
    logic             busy_o, spi_valid_o;
    logic [8:0]       spi_data_o;

    function automatic logic [8:0] win_byte(input logic [7:0] cmd, input logic [8:0] a,
                                            input logic [8:0] b, input logic [2:0] idx);
        case (idx)
            3'd0:    win_byte = {1'b0, cmd};
            3'd1:    win_byte = {1'b1, 7'd0, a[8]};
            3'd2:    win_byte = {1'b1, a[7:0]};
            3'd3:    win_byte = {1'b1, 7'd0, b[8]};
            default: win_byte = {1'b1, b[7:0]};
        endcase
    endfunction

    // Winner selection and rectangle validation, evaluated while in ARB.
    always_comb begin
        win = bus.req_valid[1] && (!bus.req_valid[0] || !rr_q);
        ax0 = win ? bus.req_x0[17:9] : bus.req_x0[8:0];
        ax1 = win ? bus.req_x1[17:9] : bus.req_x1[8:0];
        ay0 = win ? bus.req_y0[17:9] : bus.req_y0[8:0];
        ay1 = win ? bus.req_y1[17:9] : bus.req_y1[8:0];
`ifdef TFT_WIN_CLIP_EN
        if ({23'd0, ax1} > TFT_WIDTH - 1)  ax1 = 9'(TFT_WIDTH - 1);
        if ({23'd0, ay1} > TFT_HEIGHT - 1) ay1 = 9'(TFT_HEIGHT - 1);
        rect_ok = (ax0 <= ax1) && (ay0 <= ay1) &&
                  ({23'd0, ax0} < TFT_WIDTH) && ({23'd0, ay0} < TFT_HEIGHT);
`else
        rect_ok = (ax0 <= ax1) && (ay0 <= ay1);
`endif
        w    = {1'b0, ax1} - {1'b0, ax0} + 10'd1;
        h    = {1'b0, ay1} - {1'b0, ay0} + 10'd1;
        npix = CNT_W'(w) * CNT_W'(h);
        pix  = gnt_q ? bus.pix_data[31:16] : bus.pix_data[15:0];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        cnt_d       = cnt_q;
        grant_o     = 2'b00;
        err_o       = 2'b00;
        pix_ready_o = 2'b00;
        done_o      = 2'b00;
        busy_o      = 1'b0;
        spi_valid_o = 1'b0;
        spi_data_o  = 9'd0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req_valid) state_d = S_ARB;
            end
            S_ARB: begin
                state_d = S_IDLE;
                if (|bus.req_valid) begin
                    if (rect_ok) begin
                        grant_o[win] = 1'b1;
                        busy_o       = 1'b1;
                        gnt_d        = win;
                        x0_d         = ax0;
                        x1_d         = ax1;
                        y0_d         = ay0;
                        y1_d         = ay1;
                        cnt_d        = npix;
                        idx_d        = 3'd0;
                        state_d      = S_CASET;
                    end else begin
                        err_o[win] = 1'b1;
                    end
                end
            end
            S_CASET, S_PASET: begin
                busy_o      = 1'b1;
                spi_valid_o = 1'b1;
                spi_data_o  = (state_q == S_CASET) ? win_byte(8'h2A, x0_q, x1_q, idx_q)
                                                   : win_byte(8'h2B, y0_q, y1_q, idx_q);
                if (bus.spi_ready) begin
                    if (idx_q == 3'd4) begin
                        idx_d   = 3'd0;
                        state_d = (state_q == S_CASET) ? S_PASET : S_RAMWR;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_RAMWR: begin
                busy_o      = 1'b1;
                spi_valid_o = 1'b1;
                spi_data_o  = 9'h02C;
                if (bus.spi_ready) state_d = S_PIX_HI;
            end
            S_PIX_HI: begin
                busy_o      = 1'b1;
                spi_valid_o = bus.pix_valid[gnt_q];
                spi_data_o  = {1'b1, pix[15:8]};
                if (bus.pix_valid[gnt_q] && bus.spi_ready) state_d = S_PIX_LO;
            end
            S_PIX_LO: begin
                // Low byte comes from the same word, still held by the requester.
                busy_o      = 1'b1;
                spi_valid_o = 1'b1;
                spi_data_o  = {1'b1, pix[7:0]};
                if (bus.spi_ready) begin
                    pix_ready_o[gnt_q] = 1'b1;
                    cnt_d              = cnt_q - CNT_W'(1);
                    state_d            = (cnt_q == CNT_W'(1)) ? S_DONE : S_PIX_HI;
                end
            end
            S_DONE: begin
                busy_o        = 1'b1;
                done_o[gnt_q] = 1'b1;
                rr_d          = gnt_q;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b1;
            x0_q    <= 9'd0;
            x1_q    <= 9'd0;
            y0_q    <= 9'd0;
            y1_q    <= 9'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_grant = grant_o;
    assign bus.req_err   = err_o;
    assign bus.pix_ready = pix_ready_o;
    assign bus.done      = done_o;
    assign bus.busy      = busy_o;
    assign bus.spi_valid = spi_valid_o;
    assign bus.spi_data  = spi_data_o;
endmodule

// File: tb/tb_tft_ili9341_window_arbiter.sv
// Scoreboard bench for tft_ili9341_window_arbiter: stimulus pushes expected SPI bytes,
// grant/err events, done pulses and pixel order; a monitor pops and compares.
module tb_tft_ili9341_window_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tft_ili9341_window_arbiter_if bus();
    tft_ili9341_window_arbiter #(.TFT_WIDTH(320), .TFT_HEIGHT(240)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [8:0] x0;
        logic [8:0] x1;
        logic [8:0] y0;
        logic [8:0] y1;
    } rect_t;

    int total = 0;
    int bad = 0;
    logic [8:0]  exp_spi[$];
    int          exp_ev[$];    // requester index, +2 for req_err
    int          exp_done[$];
    logic [15:0] exp_pix0[$], exp_pix1[$];
    logic [15:0] pixq0[$], pixq1[$];
    rect_t       reqq0[$], reqq1[$];
    bit stall = 0;
    bit gap_chk = 0;
    bit seen_done = 0;
    int low_run = 0;
    int acc_cnt = 0;
    int pr_cnt0 = 0;
    int pr_cnt1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_extra(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    task automatic push_win(input logic [8:0] x0, input logic [8:0] x1,
                            input logic [8:0] y0, input logic [8:0] y1);
        exp_spi.push_back(9'h02A);
        exp_spi.push_back({1'b1, 7'd0, x0[8]});
        exp_spi.push_back({1'b1, x0[7:0]});
        exp_spi.push_back({1'b1, 7'd0, x1[8]});
        exp_spi.push_back({1'b1, x1[7:0]});
        exp_spi.push_back(9'h02B);
        exp_spi.push_back({1'b1, 7'd0, y0[8]});
        exp_spi.push_back({1'b1, y0[7:0]});
        exp_spi.push_back({1'b1, 7'd0, y1[8]});
        exp_spi.push_back({1'b1, y1[7:0]});
        exp_spi.push_back(9'h02C);
    endtask

    task automatic push_pix(input logic [15:0] v);
        exp_spi.push_back({1'b1, v[15:8]});
        exp_spi.push_back({1'b1, v[7:0]});
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (exp_spi.size() == 0 && exp_ev.size() == 0 && exp_done.size() == 0 &&
                reqq0.size() == 0 && reqq1.size() == 0 && !bus.busy) break;
        end
        check("drain", exp_spi.size() + exp_ev.size() + exp_done.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Requester and SPI-engine driver: sole writer of every DUT input except reset.
    initial begin
        logic tk0, tk1, h0, h1;
        logic [1:0] g;
        bus.req_valid = 2'b00;
        bus.req_x0 = '0; bus.req_x1 = '0; bus.req_y0 = '0; bus.req_y1 = '0;
        bus.pix_data = '0;
        bus.pix_valid = 2'b00;
        bus.spi_ready = 1'b1;
        forever begin
            @(negedge clk);
            tk0 = bus.pix_ready[0];
            tk1 = bus.pix_ready[1];
            g   = bus.req_grant | bus.req_err;
            @(posedge clk);
            #1;
            h0 = bus.pix_valid[0] && !tk0;
            h1 = bus.pix_valid[1] && !tk1;
            if (tk0 && pixq0.size() > 0) pixq0.delete(0);
            if (tk1 && pixq1.size() > 0) pixq1.delete(0);
            if (g[0] && reqq0.size() > 0) reqq0.delete(0);
            if (g[1] && reqq1.size() > 0) reqq1.delete(1 - 1);
            bus.pix_valid[0] = pixq0.size() > 0 && (h0 || !stall || $urandom_range(0, 1) == 1);
            bus.pix_valid[1] = pixq1.size() > 0 && (h1 || !stall || $urandom_range(0, 1) == 1);
            bus.pix_data[15:0]  = pixq0.size() > 0 ? pixq0[0] : 16'h0;
            bus.pix_data[31:16] = pixq1.size() > 0 ? pixq1[0] : 16'h0;
            bus.req_valid = {reqq1.size() > 0, reqq0.size() > 0};
            if (reqq0.size() > 0) begin
                bus.req_x0[8:0] = reqq0[0].x0; bus.req_x1[8:0] = reqq0[0].x1;
                bus.req_y0[8:0] = reqq0[0].y0; bus.req_y1[8:0] = reqq0[0].y1;
            end
            if (reqq1.size() > 0) begin
                bus.req_x0[17:9] = reqq1[0].x0; bus.req_x1[17:9] = reqq1[0].x1;
                bus.req_y0[17:9] = reqq1[0].y0; bus.req_y1[17:9] = reqq1[0].y1;
            end
            bus.spi_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every DUT output event.
    initial begin
        bit prev_stall = 0;
        logic [8:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check("spi_hold_valid", bus.spi_valid, 1);
                check("spi_hold_data", bus.spi_data, prev_data);
            end
            prev_stall = bus.spi_valid && !bus.spi_ready;
            prev_data  = bus.spi_data;
            if (bus.spi_valid && bus.spi_ready) begin
                acc_cnt++;
                if (exp_spi.size() == 0) fail_extra("spi_byte", bus.spi_data);
                else check("spi_byte", bus.spi_data, exp_spi.pop_front());
            end
            for (int r = 0; r < 2; r++) begin
                if (bus.req_grant[r] || bus.req_err[r]) begin
                    if (exp_ev.size() == 0) fail_extra("grant_err", r + (bus.req_err[r] ? 2 : 0));
                    else check("grant_err", r + (bus.req_err[r] ? 2 : 0), exp_ev.pop_front());
                end
                if (bus.done[r]) begin
                    if (exp_done.size() == 0) fail_extra("done", r);
                    else check("done", r, exp_done.pop_front());
                end
            end
            if (bus.pix_ready[0]) begin
                pr_cnt0++;
                if (exp_pix0.size() == 0) fail_extra("pix_ready0", bus.pix_data[15:0]);
                else check("pix_ready0", bus.pix_data[15:0], exp_pix0.pop_front());
            end
            if (bus.pix_ready[1]) begin
                pr_cnt1++;
                if (exp_pix1.size() == 0) fail_extra("pix_ready1", bus.pix_data[31:16]);
                else check("pix_ready1", bus.pix_data[31:16], exp_pix1.pop_front());
            end
            if (!bus.busy) low_run++;
            else begin
                if (gap_chk && seen_done) begin
                    check("busy_gap", low_run, 1);
                    seen_done = 0;
                end
                low_run = 0;
            end
            if (|bus.done) seen_done = 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0;
        logic [15:0] v;
        // Reset held 3 cycles: all outputs low
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", bus.req_grant, 0);
        check("rst_err", bus.req_err, 0);
        check("rst_pix_ready", bus.pix_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_spi_valid", bus.spi_valid, 0);
        check("rst_spi_data", bus.spi_data, 0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_spi_valid", bus.spi_valid, 0);
        end

        // 2-pixel window on requester 0
        @(negedge clk);
        p0 = pr_cnt0;
        foreach (exp_spi[i]) exp_spi.delete(i);
        exp_spi = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100,
                    9'h100, 9'h100, 9'h02C, 9'h1AB, 9'h1CD, 9'h112, 9'h134};
        exp_ev.push_back(0);
        exp_done.push_back(0);
        exp_pix0.push_back(16'hABCD); exp_pix0.push_back(16'h1234);
        pixq0.push_back(16'hABCD); pixq0.push_back(16'h1234);
        reqq0.push_back('{x0: 9'd0, x1: 9'd1, y0: 9'd0, y1: 9'd0});
        wait_drain(300);
        check("t2_pix_ready_cnt", pr_cnt0 - p0, 2);

        // Both requesters held: alternate 0,1,0,1
        do_reset();
        @(negedge clk);
        seen_done = 0;
        gap_chk = 1;
        push_win(9'd1, 9'd1, 9'd1, 9'd1); push_pix(16'h1111);
        push_win(9'd2, 9'd2, 9'd2, 9'd2); push_pix(16'h2222);
        push_win(9'd1, 9'd1, 9'd1, 9'd1); push_pix(16'h3333);
        push_win(9'd2, 9'd2, 9'd2, 9'd2); push_pix(16'h4444);
        exp_ev = '{0, 1, 0, 1};
        exp_done = '{0, 1, 0, 1};
        exp_pix0 = '{16'h1111, 16'h3333};
        exp_pix1 = '{16'h2222, 16'h4444};
        pixq0 = '{16'h1111, 16'h3333};
        pixq1 = '{16'h2222, 16'h4444};
        reqq0.push_back('{x0: 9'd1, x1: 9'd1, y0: 9'd1, y1: 9'd1});
        reqq0.push_back('{x0: 9'd1, x1: 9'd1, y0: 9'd1, y1: 9'd1});
        reqq1.push_back('{x0: 9'd2, x1: 9'd2, y0: 9'd2, y1: 9'd2});
        reqq1.push_back('{x0: 9'd2, x1: 9'd2, y0: 9'd2, y1: 9'd2});
        wait_drain(500);
        gap_chk = 0;

        // 4x3 window with random SPI and pixel stalls
        @(negedge clk);
        a0 = acc_cnt;
        p0 = pr_cnt0;
        stall = 1;
        push_win(9'd10, 9'd13, 9'd20, 9'd22);
        for (int i = 0; i < 12; i++) begin
            v = 16'hA000 + 16'(i * 16'h0111);
            push_pix(v);
            exp_pix0.push_back(v);
            pixq0.push_back(v);
        end
        exp_ev.push_back(0);
        exp_done.push_back(0);
        reqq0.push_back('{x0: 9'd10, x1: 9'd13, y0: 9'd20, y1: 9'd22});
        wait_drain(2000);
        stall = 0;
        check("t4_byte_cnt", acc_cnt - a0, 11 + 24);
        check("t4_pix_ready_cnt", pr_cnt0 - p0, 12);

        // Inverted rectangle rejected with no SPI traffic
        @(negedge clk);
        exp_ev.push_back(3);
        reqq1.push_back('{x0: 9'd10, x1: 9'd5, y0: 9'd0, y1: 9'd0});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_no_spi", bus.spi_valid, 0);
        end
        check("t5_err_seen", exp_ev.size(), 0);
`ifdef TFT_WIN_CLIP_EN
        // x1=400 clamps to 319
        exp_spi = '{9'h02A, 9'h101, 9'h12C, 9'h101, 9'h13F, 9'h02B, 9'h100, 9'h100,
                    9'h100, 9'h100, 9'h02C};
        for (int i = 0; i < 20; i++) begin
            v = 16'h0C00 + 16'(i);
            push_pix(v);
            exp_pix1.push_back(v);
            pixq1.push_back(v);
        end
        exp_ev.push_back(1);
        exp_done.push_back(1);
        reqq1.push_back('{x0: 9'd300, x1: 9'd400, y0: 9'd0, y1: 9'd0});
        wait_drain(1000);
`endif

        // Reset during the third pixel abandons the transfer
        @(negedge clk);
        push_win(9'd0, 9'd3, 9'd0, 9'd0);
        for (int i = 0; i < 4; i++) begin
            v = 16'h5A01 + 16'(i);
            push_pix(v);
            exp_pix0.push_back(v);
            pixq0.push_back(v);
        end
        exp_ev.push_back(0);
        exp_done.push_back(0);
        reqq0.push_back('{x0: 9'd0, x1: 9'd3, y0: 9'd0, y1: 9'd0});
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_pix0.size() <= 2) break;
        end
        check("t6_two_pixels", exp_pix0.size(), 2);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        exp_spi.delete(); exp_ev.delete(); exp_done.delete(); exp_pix0.delete();
        pixq0.delete(); reqq0.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("t6_spi_valid", bus.spi_valid, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_pix_ready", bus.pix_ready, 0);
        check("t6_done", bus.done, 0);
        repeat (5) @(negedge clk);
        push_win(9'd5, 9'd5, 9'd5, 9'd5);
        push_pix(16'h0F0F);
        exp_pix1.push_back(16'h0F0F);
        pixq1.push_back(16'h0F0F);
        exp_ev.push_back(1);
        exp_done.push_back(1);
        reqq1.push_back('{x0: 9'd5, x1: 9'd5, y0: 9'd5, y1: 9'd5});
        wait_drain(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
